// File: rtl/vga_layer_engine.sv
// VGA raster engine: sync generation plus a priority-ordered stack of solid rectangles.
// Define VGA_LAYER_BLINK_EN to enable per-slot blinking driven by a committed-frame counter.
module vga_layer_engine #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter bit          SYNC_ACTIVE  = 1'b0,
  parameter int unsigned NUM_RECTS    = 8,
  parameter int unsigned COLOR_W      = 4
`ifdef VGA_LAYER_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 30
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pix_ce,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_idx,
  input  logic [9:0]           cfg_x0,
  input  logic [9:0]           cfg_x1,
  input  logic [9:0]           cfg_y0,
  input  logic [9:0]           cfg_y1,
  input  logic [3*COLOR_W-1:0] cfg_color,
  input  logic                 cfg_en,
  input  logic                 cfg_blink,
  input  logic [3*COLOR_W-1:0] bg_color,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 de,
  output logic                 frame_start
);

  localparam int unsigned RGB_W   = 3 * COLOR_W;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic             en;
    logic             blink;
    logic [9:0]       x0;
    logic [9:0]       x1;
    logic [9:0]       y0;
    logic [9:0]       y1;
    logic [RGB_W-1:0] color;
  } rect_t;

  logic [9:0]           hc_q, hc_d;
  logic [9:0]           vc_q, vc_d;
  logic                 end_of_line;
  logic                 end_of_frame;
  logic                 commit;

  rect_t                shadow_q [NUM_RECTS];
  rect_t                live_q   [NUM_RECTS];
  rect_t                cfg_rect;

  logic [NUM_RECTS-1:0] hit_d, hit_q;
  logic                 de1_d, hs1_d, vs1_d;
  logic                 de1_q, hs1_q, vs1_q;
  logic                 de_q, hs_q, vs_q;
  logic [RGB_W-1:0]     rgb_d, rgb_q;
  logic                 frame_start_q;
  logic                 blink_phase;

  // Raster counters
  always_comb begin
    end_of_line  = (hc_q == H_LAST);
    end_of_frame = end_of_line && (vc_q == V_LAST);
    commit       = pix_ce && end_of_frame;
    hc_d         = end_of_line ? 10'd0 : hc_q + 10'd1;
    vc_d         = vc_q;
    if (end_of_line) begin
      vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else if (pix_ce) begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Descriptor banks: upstream only ever writes the shadow bank
  always_comb begin
    cfg_rect       = '0;
    cfg_rect.en    = cfg_en;
    cfg_rect.blink = cfg_blink;
    cfg_rect.x0    = cfg_x0;
    cfg_rect.x1    = cfg_x1;
    cfg_rect.y0    = cfg_y0;
    cfg_rect.y1    = cfg_y1;
    cfg_rect.color = cfg_color;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_RECTS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (cfg_we) begin
      // Out-of-range indices match no slot and are dropped
      for (int unsigned i = 0; i < NUM_RECTS; i++) begin
        if (cfg_idx == 4'(i)) begin
          shadow_q[i] <= cfg_rect;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_RECTS; i++) begin
        live_q[i] <= '0;
      end
    end else if (commit) begin
      for (int unsigned i = 0; i < NUM_RECTS; i++) begin
        live_q[i] <= shadow_q[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= commit;
    end
  end

`ifdef VGA_LAYER_BLINK_EN
  localparam int unsigned BLINK_CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_CNT_W-1:0] blink_cnt_q;
  logic                   blink_phase_q;

  // Phase only moves at commit, so a slot is either fully drawn or fully hidden in a frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (commit) begin
      if (blink_cnt_q == BLINK_CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blink_phase = blink_phase_q;
`else
  assign blink_phase = 1'b0;
`endif

  // Stage 1: per-slot hit test and raw sync/enable
  always_comb begin
    hit_d = '0;
    for (int unsigned i = 0; i < NUM_RECTS; i++) begin
      hit_d[i] = live_q[i].en && !(live_q[i].blink && blink_phase) &&
                 (live_q[i].x0 <= hc_q) && (hc_q <= live_q[i].x1) &&
                 (live_q[i].y0 <= vc_q) && (vc_q <= live_q[i].y1);
    end
    de1_d = (hc_q < H_ACT) && (vc_q < V_ACT);
    hs1_d = ((hc_q >= HS_FIRST) && (hc_q <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs1_d = ((vc_q >= VS_FIRST) && (vc_q <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // Stage 2: later slots overwrite earlier ones, so the highest hitting index wins
  always_comb begin
    rgb_d = bg_color;
    for (int unsigned i = 0; i < NUM_RECTS; i++) begin
      if (hit_q[i]) begin
        rgb_d = live_q[i].color;
      end
    end
    if (!de1_q) begin
      rgb_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_q <= '0;
      de1_q <= 1'b0;
      hs1_q <= ~SYNC_ACTIVE;
      vs1_q <= ~SYNC_ACTIVE;
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
      rgb_q <= '0;
    end else if (pix_ce) begin
      hit_q <= hit_d;
      de1_q <= de1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      de_q  <= de1_q;
      hs_q  <= hs1_q;
      vs_q  <= vs1_q;
      rgb_q <= rgb_d;
    end
  end

  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign de          = de_q;
  assign red         = rgb_q[RGB_W-1 -: COLOR_W];
  assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue        = rgb_q[COLOR_W-1:0];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_layer_engine.sv
// Bench for vga_layer_engine using a shrunken raster (24x17 totals) so whole frames run quickly.
module tb_vga_layer_engine;

  localparam int HT = 24;
  localparam int VT = 17;
  localparam int FR = HT * VT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [9:0]  cfg_x0 = '0, cfg_x1 = '0, cfg_y0 = '0, cfg_y1 = '0;
  logic [11:0] cfg_color = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_blink = 1'b0;
  logic [11:0] bg_color = '0;
  logic        h_sync, v_sync, de, frame_start;
  logic [3:0]  red, green, blue;

  int ce_cnt  = 0;
  int fs_cnt  = 0;
  int fs_last = -1;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         f;
    int         x;
    int         y;
    logic [11:0] rgb;
    logic       de;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t vecs[$];
  int   seg_end[5];

  vga_layer_engine #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_ACTIVE(1'b0), .NUM_RECTS(8), .COLOR_W(4)
  ) dut (
    .clock(clock), .reset(reset), .pix_ce(pix_ce),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
    .cfg_color(cfg_color), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
    .bg_color(bg_color),
    .h_sync(h_sync), .v_sync(v_sync),
    .red(red), .green(green), .blue(blue),
    .de(de), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(negedge clock);
    pix_ce = ~pix_ce;
  end

  // Counts pixel-enable edges since reset release: after E edges the outputs show pixel E-2
  initial forever begin
    @(posedge clock);
    if (!reset) ce_cnt = 0;
    else if (pix_ce) ce_cnt++;
  end

  initial forever begin
    @(negedge clock);
    if (frame_start) begin
      fs_cnt++;
      fs_last = ce_cnt;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ce(input int target);
    int budget;
    budget = 4 * (target - ce_cnt) + 8;
    while (ce_cnt < target && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (ce_cnt != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ce: reached %0d, expected %0d", ce_cnt, target);
    end
  endtask

  task automatic write_rect(input logic [3:0] idx, input int x0, input int x1, input int y0,
                            input int y1, input logic [11:0] color, input logic en);
    cfg_idx   = idx;
    cfg_x0    = 10'(x0);
    cfg_x1    = 10'(x1);
    cfg_y0    = 10'(y0);
    cfg_y1    = 10'(y1);
    cfg_color = color;
    cfg_en    = en;
    cfg_we    = 1'b1;
    @(negedge clock);
    cfg_we    = 1'b0;
  endtask

  task automatic add(input int f, input int x, input int y, input logic [11:0] rgb,
                     input logic d, input logic hs, input logic vs);
    vecs.push_back('{f, x, y, rgb, d, hs, vs});
  endtask

  task automatic run_seg(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      vec_t  v;
      string nm;
      logic [14:0] exp;
      v   = vecs[i];
      nm  = $sformatf("pixel f%0d (%0d,%0d)", v.f, v.x, v.y);
      exp = {v.rgb, v.de, v.hs, v.vs};
      wait_ce(v.f * FR + v.y * HT + v.x + 2);
      check(nm, 32'({red, green, blue, de, h_sync, v_sync}), 32'(exp));
      // The following edge has pix_ce low: outputs must hold
      @(negedge clock);
      check({nm, " hold"}, 32'({red, green, blue, de, h_sync, v_sync}), 32'(exp));
    end
  endtask

  initial begin
    // Frame 0: writes land in shadow only; sync timing checks
    add(0, 17, 1, 12'h000, 0, 1, 1);
    add(0, 18, 1, 12'h000, 0, 0, 1);
    add(0, 20, 1, 12'h000, 0, 0, 1);
    add(0, 21, 1, 12'h000, 0, 1, 1);
    add(0,  5, 4, 12'h000, 1, 1, 1);
    add(0, 15, 11, 12'h000, 1, 1, 1);
    add(0, 16, 11, 12'h000, 0, 1, 1);
    add(0,  0, 12, 12'h000, 0, 1, 1);
    add(0,  0, 13, 12'h000, 0, 1, 0);
    add(0,  0, 14, 12'h000, 0, 1, 0);
    add(0,  0, 15, 12'h000, 0, 1, 1);
    seg_end[0] = vecs.size();
    // Frame 1: committed slots 0, 5, 3 (degenerate), 2 (wide); idx 15 ignored
    add(1,  0, 0, 12'h000, 1, 1, 1);
    add(1,  9, 1, 12'h000, 1, 1, 1);
    add(1, 10, 1, 12'h000, 1, 1, 1);
    add(1,  3, 3, 12'h000, 1, 1, 1);
    add(1,  4, 3, 12'hF00, 1, 1, 1);
    add(1,  9, 3, 12'hF00, 1, 1, 1);
    add(1, 10, 3, 12'h000, 1, 1, 1);
    add(1,  8, 6, 12'h0F0, 1, 1, 1);
    add(1,  4, 7, 12'hF00, 1, 1, 1);
    add(1,  4, 8, 12'h000, 1, 1, 1);
    add(1, 12, 9, 12'h0F0, 1, 1, 1);
    add(1, 13, 9, 12'h000, 1, 1, 1);
    add(1, 11, 10, 12'h000, 1, 1, 1);
    add(1, 12, 10, 12'h0FF, 1, 1, 1);
    add(1, 15, 10, 12'h0FF, 1, 1, 1);
    add(1, 16, 10, 12'h000, 0, 1, 1);
    seg_end[1] = vecs.size();
    // Frame 2: slot 5 disabled, background 123, slot 6 written at the commit edge
    add(2,  0, 0, 12'h123, 1, 1, 1);
    add(2,  8, 6, 12'hF00, 1, 1, 1);
    add(2, 12, 9, 12'h123, 1, 1, 1);
    add(2, 15, 10, 12'h0FF, 1, 1, 1);
    add(2, 16, 10, 12'h000, 0, 1, 1);
    seg_end[2] = vecs.size();
    // Frame 3: slot 6 now live; last vector sits at hc=8, vc=5 just before reset
    add(3,  0, 0, 12'hABC, 1, 1, 1);
    add(3,  1, 0, 12'hABC, 1, 1, 1);
    add(3,  2, 0, 12'h123, 1, 1, 1);
    add(3,  6, 5, 12'hF00, 1, 1, 1);
    seg_end[3] = vecs.size();
    // After mid-frame reset: raster restarts, both banks empty
    add(0, 17, 0, 12'h000, 0, 1, 1);
    add(0, 18, 0, 12'h000, 0, 0, 1);
    add(0,  5, 4, 12'h123, 1, 1, 1);
    add(1,  0, 0, 12'h123, 1, 1, 1);
    add(1,  5, 4, 12'h123, 1, 1, 1);
    seg_end[4] = vecs.size();

    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset outputs", 32'({red, green, blue, de, h_sync, v_sync}), 32'({12'h000, 3'b011}));
    check("reset frame_start", 32'(frame_start), 32'(0));
    reset = 1'b1;

    write_rect(4'd0, 4, 9, 3, 7, 12'hF00, 1'b1);
    write_rect(4'd5, 7, 12, 6, 9, 12'h0F0, 1'b1);
    write_rect(4'd3, 10, 9, 0, 11, 12'h00F, 1'b1);
    write_rect(4'd2, 12, 1023, 10, 10, 12'h0FF, 1'b1);
    write_rect(4'd15, 0, 1023, 0, 1023, 12'hFFF, 1'b1);

    run_seg(0, seg_end[0]);
    run_seg(seg_end[0], seg_end[1]);
    check("frame_start count f1", 32'(fs_cnt), 32'(1));
    check("frame_start edge f1", 32'(fs_last), 32'(FR));

    write_rect(4'd5, 7, 12, 6, 9, 12'h0F0, 1'b0);
    bg_color = 12'h123;
    // Hold cfg_we across the commit edge: captured in shadow, deferred one frame
    wait_ce(2 * FR - 1);
    @(negedge clock);
    write_rect(4'd6, 0, 1, 0, 0, 12'hABC, 1'b1);

    run_seg(seg_end[1], seg_end[2]);
    check("frame_start count f2", 32'(fs_cnt), 32'(2));
    check("frame_start edge f2", 32'(fs_last), 32'(2 * FR));

    run_seg(seg_end[2], seg_end[3]);
    #1 reset = 1'b0;
    #1;
    check("mid-frame reset outputs", 32'({red, green, blue, de, h_sync, v_sync}),
          32'({12'h000, 3'b011}));
    check("mid-frame reset frame_start", 32'(frame_start), 32'(0));
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_seg(seg_end[3], seg_end[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_layer_engine.md
Name: vga_layer_engine

Overview:
- Parametrised VGA raster engine: sync generation plus a priority-ordered stack of NUM_RECTS solid rectangles over a background colour.
- Sits between the system FSM/status logic and the VGA DAC pins.
- Replaces per-screen hard-coded rectangle chains: upstream logic writes rectangle descriptors through a config port.
- Writes are double-buffered and committed at frame boundary, so the display never tears.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_ACTIVE, 0, level of h_sync/v_sync during the pulse
- NUM_RECTS, 8, rectangle slots (1..16)
- COLOR_W, 4, bits per colour channel

Ports:
- clock, in, 1, system clock (50 MHz)
- reset, in, 1, asynchronous active-low reset
- pix_ce, in, 1, pixel clock enable (every 2nd clock at 50 MHz)
- cfg_we, in, 1, write one descriptor to the shadow bank
- cfg_idx, in, 4, slot index; writes with idx >= NUM_RECTS are ignored
- cfg_x0 / cfg_x1, in, 10 each, inclusive horizontal bounds, active-area coordinates
- cfg_y0 / cfg_y1, in, 10 each, inclusive vertical bounds
- cfg_color, in, 3*COLOR_W, {r,g,b}
- cfg_en, in, 1, slot visible
- cfg_blink, in, 1, slot blinks (effective only with the optional feature)
- bg_color, in, 3*COLOR_W, background {r,g,b}, sampled per pixel
- h_sync, out, 1, horizontal sync
- v_sync, out, 1, vertical sync
- red / green / blue, out, COLOR_W each, pixel colour
- de, out, 1, data enable (visible pixel)
- frame_start, out, 1, one-clock pulse when the committed bank updates

Behaviour:
- Timing derivation:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800).
  - V_TOTAL is the vertical equivalent (525).
- Counters (10-bit):
  - hc and vc advance only on clock edges with pix_ce = 1.
  - hc wraps H_TOTAL-1 -> 0.
  - vc increments when hc wraps, and wraps V_TOTAL-1 -> 0 (exactly V_TOTAL lines).
- Line/frame order: active, front porch, sync, back porch; this applies to both h and v.
  - Pixel (0,0) is hc = 0, vc = 0.
  - h_sync is at SYNC_ACTIVE for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; v likewise.
- Reset:
  - hc = vc = 0.
  - h_sync = v_sync = !SYNC_ACTIVE.
  - de = 0, rgb = 0, frame_start = 0.
  - Shadow and live banks are cleared: all slots have en = 0 and coords/colour = 0.
- Config port:
  - cfg_we writes the shadow slot on the same clock, independent of pix_ce.
  - The live bank is never written directly.
- Commit:
  - On the pix_ce edge where hc = H_TOTAL-1 and vc = V_TOTAL-1, live <= shadow (all slots, atomically).
  - frame_start pulses high for that one clock.
  - A cfg_we in the same clock is captured in the shadow bank but not committed until the next frame.
- Hit test per slot i: en && x0 <= hc <= x1 && y0 <= vc <= y1.
  - A slot with x0 > x1 or y0 > y1 never hits.
  - Bounds beyond the active area are clipped by de.
- Priority: the highest index that hits supplies the colour; if no slot hits, bg_color is used.
- Pipeline: 2 pix_ce stages.
  - Stage 1: per-slot hit vector registered.
  - Stage 2: priority mux registered to rgb.
  - h_sync, v_sync and de are delayed by the same 2 stages, so all outputs stay aligned.
- Blanking: rgb = 0 whenever the delayed de = 0.
- Outputs hold their values on cycles where pix_ce = 0.
- Reset mid-frame: asynchronous clear to the reset values above; the raster restarts at (0,0) on the first pix_ce after release.

Optional Feature:
- Macro: VGA_LAYER_BLINK_EN.
- Defined:
  - Adds parameter BLINK_FRAMES (default 30).
  - A frame counter toggles blink_phase every BLINK_FRAMES committed frames.
  - A slot with blink = 1 is treated as en = 0 while blink_phase = 1.
  - blink_phase resets to 0 and changes only at commit, so no mid-frame flicker.
- Undefined: cfg_blink is ignored and there is no frame counter.

Test Plan:
- Free-run defaults, no config writes:
  - Required: hc period 800 pix_ce.
  - Required: h_sync low for 96 pix_ce starting at hc = 656.
  - Required: v_sync low for 2 lines starting at vc = 490.
  - Required: 525 lines per frame; de asserted for 640x480.
  - Required: frame_start once per 420000 pix_ce.
- Write slot 0 = (100,50)-(199,149), red F00, en; bg = 000:
  - Required: no effect in the current frame.
  - Required: next frame, rgb = F,0,0 exactly at pixels x 100..199, y 50..149, appearing 2 pix_ce after the matching hc/vc.
  - Required: 000 elsewhere.
- Slots 0 and 5 overlap at (120,60):
  - Required: slot 5 colour wins.
  - Disable slot 5 and commit: slot 0 colour appears.
- Degenerate and boundary slots:
  - Slot with x0 = 300, x1 = 299: never drawn.
  - Slot with x1 = 1023: clipped at x = 639; rgb = 0 during blanking.
  - cfg_idx = 15 with NUM_RECTS = 8: no change.
- Assert reset mid-line at hc = 400, vc = 200:
  - Required: outputs go immediately to the reset values and both banks clear.
  - Required: after release, first h_sync pulse at hc = 656 of line 0.
- With VGA_LAYER_BLINK_EN, BLINK_FRAMES = 2, slot blink = 1:
  - Required: visible 2 frames, hidden 2 frames, repeating.
  - Required: the slot is never partially drawn within a frame.
